// File: rtl/ex_sequencer_pkg.sv
// ex_sequencer_pkg: shared state encodings, opcode constants and ALU codes
// for the multi-cycle instruction sequencer.
`default_nettype none

package ex_sequencer_pkg;

    localparam int WORD = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_FAULT     = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CL_LDUR  = 3'd0,
        CL_STUR  = 3'd1,
        CL_RTYPE = 3'd2,
        CL_CBZ   = 3'd3,
        CL_B     = 3'd4
    } op_class_t;

    localparam logic [10:0] c_OP_LDUR    = 11'b11111000010;
    localparam logic [10:0] c_OP_STUR    = 11'b11111000000;
    localparam logic [10:0] c_OP_ADD     = 11'b10001011000;
    localparam logic [10:0] c_OP_SUB     = 11'b11001011000;
    localparam logic [10:0] c_OP_AND     = 11'b10001010000;
    localparam logic [10:0] c_OP_ORR     = 11'b10101010000;
    localparam logic [7:0]  c_OP_CBZ_PFX = 8'b10110100;
    localparam logic [5:0]  c_OP_B_PFX   = 6'b000101;

    localparam logic [1:0] c_ALU_ADD   = 2'b00;
    localparam logic [1:0] c_ALU_PASSB = 2'b01;
    localparam logic [1:0] c_ALU_RTYPE = 2'b10;

endpackage

`default_nettype wire

// File: rtl/ex_sequencer_op_decoder.sv
// op_decoder: combinational classification of instruction bits [31:21]
// into an instruction class plus an illegal-opcode flag.
`default_nettype none

module op_decoder
    import ex_sequencer_pkg::*;
(
    input  logic [10:0] i_opcode,
    output op_class_t   o_class,
    output logic        o_illegal
);

    always_comb begin
        o_class   = CL_RTYPE;
        o_illegal = 1'b0;
        if (i_opcode == c_OP_LDUR) begin
            o_class = CL_LDUR;
        end else if (i_opcode == c_OP_STUR) begin
            o_class = CL_STUR;
        end else if (i_opcode == c_OP_ADD || i_opcode == c_OP_SUB ||
                     i_opcode == c_OP_AND || i_opcode == c_OP_ORR) begin
            o_class = CL_RTYPE;
        end else if (i_opcode[10:3] == c_OP_CBZ_PFX) begin
            o_class = CL_CBZ;
        end else if (i_opcode[10:5] == c_OP_B_PFX) begin
            o_class = CL_B;
        end else begin
            o_illegal = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ex_sequencer.sv
// ex_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control FSM
// with memory-wait timeout, sticky fault and retired-instruction counter.
`default_nettype none

module ex_sequencer
    import ex_sequencer_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [10:0]      opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic [2:0]       state,
    output logic             busy,
    output logic             instr_done,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    localparam int c_WAIT_W = $clog2(MEM_WAIT_MAX + 1);

    state_t              r_state;
    state_t              w_next;
    op_class_t           r_class;
    op_class_t           w_dec_class;
    logic                w_dec_illegal;
    logic [c_WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]    r_count;
    logic                w_retire;
    logic                w_mem_phase;
    logic                w_wait_expired;

    op_decoder u_op_decoder (
        .i_opcode  (opcode),
        .o_class   (w_dec_class),
        .o_illegal (w_dec_illegal)
    );

    assign w_mem_phase    = (r_state == ST_FETCH) || (r_state == ST_MEMORY);
    // Fires on the cycle that would be the MEM_WAIT_MAX-th unanswered wait.
    assign w_wait_expired = !mem_ready && (r_wait == c_WAIT_W'(MEM_WAIT_MAX - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_class <= CL_RTYPE;
            r_wait  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_class <= w_dec_class;
            end
            if (w_mem_phase && !mem_ready) begin
                r_wait <= r_wait + 1'b1;
            end else begin
                r_wait <= '0;
            end
            if (w_retire) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_retire   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = c_ALU_ADD;
        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = ST_DECODE;
                end else if (w_wait_expired) begin
                    w_next = ST_FAULT;
                end
            end
            ST_DECODE: begin
                w_next = w_dec_illegal ? ST_FAULT : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                case (r_class)
                    CL_RTYPE: begin
                        alu_op = c_ALU_RTYPE;
                        w_next = ST_WRITEBACK;
                    end
                    CL_LDUR, CL_STUR: begin
                        alu_src = 1'b1;
                        w_next  = ST_MEMORY;
                    end
                    CL_CBZ: begin
                        alu_op   = c_ALU_PASSB;
                        pc_src   = 1'b1;
                        pc_write = zero;
                        w_retire = 1'b1;
                    end
                    CL_B: begin
                        pc_src   = 1'b1;
                        pc_write = 1'b1;
                        w_retire = 1'b1;
                    end
                    default: w_next = ST_FAULT;
                endcase
            end
            ST_MEMORY: begin
                mem_read  = (r_class == CL_LDUR);
                mem_write = (r_class == CL_STUR);
                if (mem_ready) begin
                    if (r_class == CL_LDUR) begin
                        w_next = ST_WRITEBACK;
                    end else begin
                        w_retire = 1'b1;
                    end
                end else if (w_wait_expired) begin
                    w_next = ST_FAULT;
                end
            end
            ST_WRITEBACK: begin
                reg_write  = 1'b1;
                mem_to_reg = (r_class == CL_LDUR);
                w_retire   = 1'b1;
            end
            ST_FAULT: begin
                w_next = ST_FAULT;
            end
            default: w_next = ST_FAULT;
        endcase
        if (w_retire) begin
            w_next = run ? ST_FETCH : ST_IDLE;
        end
    end

    assign state       = r_state;
    assign busy        = (r_state != ST_IDLE) && (r_state != ST_FAULT);
    assign fault       = (r_state == ST_FAULT);
    assign instr_done  = w_retire;
    assign instr_count = r_count;

endmodule

`default_nettype wire
